calc_sequencer: RTL
===================

Name: calc_sequencer

Overview:
- Control FSM for the two-function calculator datapath (A/B operand registers, iterative shift-add multiplier / restoring divider, Z result register).
- Sequences operand entry from a single pushbutton, runs the multi-cycle operation, captures the result and flags divide-by-zero.
- Replaces the single-step load sequencing with a full enter → compute → display flow that includes busy/done status.

Parameters:
- WIDTH, 8, operand width; RUN lasts exactly WIDTH cycles.
- ITER_W, 4, iteration counter width; must satisfy 2**ITER_W >= WIDTH.

Ports:
- clk  in  1  system clock, all state on rising edge
- clr  in  1  asynchronous active-low reset
- enter  in  1  raw pushbutton level, active-high, asynchronous to clk
- op_sel  in  1  0 = multiply, 1 = divide
- b_zero  in  1  datapath flag: B register == 0
- load_a  out  1  one-cycle strobe: capture operand A
- load_b  out  1  one-cycle strobe: capture operand B
- div_mode  out  1  latched operation for datapath
- init  out  1  one-cycle strobe: clear accumulator/remainder, preset shifter
- step  out  1  perform one iteration this cycle
- load_z  out  1  one-cycle strobe: capture result into Z
- busy  out  1  high in CHECK, RUN, STORE
- done  out  1  high in SHOW
- err  out  1  high in ERR
- iter  out  ITER_W  current iteration index
- state  out  3  state encoding for LED debug

Behaviour:
- Reset (clr=0, async): state=GET_A, iter=0, div_mode=0.
  - Synchronizer flops reset to 1, so a button held through reset must be released and re-pressed before it counts.
  - All strobes and flags are 0.
- Enter conditioning: 2-flop synchronizer plus delay flop; enter_pulse = s2 & ~s3.
  - enter_pulse is high for exactly one cycle, in the cycle after the 2nd rising edge that samples enter high.
  - One pulse per press regardless of hold time.
- States and encoding: GET_A=000, GET_B=001, CHECK=010, RUN=011, STORE=100, SHOW=101, ERR=110. Code 111 is illegal and recovers to GET_A on the next edge.
- GET_A:
  - load_a = enter_pulse (Mealy).
  - On pulse → GET_B.
- GET_B:
  - load_b = enter_pulse.
  - On pulse: div_mode <= op_sel, → CHECK.
  - op_sel changes at any other time have no effect.
- CHECK (1 cycle):
  - If div_mode=1 and b_zero=1 → ERR, with init=0.
  - Otherwise init=1 and → RUN.
- RUN:
  - step=1 every cycle, and iter increments each cycle.
  - When iter==WIDTH-1: iter <= 0, → STORE.
  - RUN is exactly WIDTH cycles.
- STORE (1 cycle): load_z=1, → SHOW.
- SHOW: done=1; enter_pulse → GET_A. That pulse does not also assert load_a.
- ERR: err=1; enter_pulse → GET_A. Z is not updated.
- Latency: enter_pulse in GET_B at cycle t gives CHECK at t+1, RUN at t+2..t+1+WIDTH, STORE at t+2+WIDTH, done=1 from t+3+WIDTH.
- enter_pulse during CHECK/RUN/STORE is dropped, not queued.
- At most one strobe among load_a, load_b, init, load_z is active in any cycle. step is never concurrent with init or load_z.
- clr asserted mid-RUN: immediate return to the reset state, with step and iter cleared asynchronously.

Decomposition:
- Package calc_pkg holds:
  - state encodings (localparams above)
  - op codes OP_MUL=0, OP_DIV=1
  - default WIDTH
- One sub-module, enter_sync: synchronizer and rising-edge detector with the async active-low reset-to-1 described above. The FSM, counter and strobes stay in calc_sequencer.

Test Plan:
- Reset with enter held high, then release and press once → exactly one load_a pulse; state 000 → 001.
- Multiply: press (load_a), op_sel=0, press (load_b), b_zero=0 → init at t+1; step high for 8 cycles with iter 0..7; load_z at t+10; done=1 from t+11; busy high t+1..t+10.
- Divide by zero: op_sel=1 at the second press, b_zero=1 → CHECK then ERR at t+2; err=1; no init, step or load_z; next press → GET_A with err=0.
- Presses during RUN (3 pulses mid-iteration) → ignored; sequence completes in the same cycle count; SHOW is reached, not GET_A.
- op_sel toggled during RUN → div_mode unchanged from the value latched at the GET_B press.
- clr pulsed low at iter=4 → state=000, iter=0, step=0 immediately; the next full operation completes normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: state codes, op codes, sizes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

   localparam int CALC_WIDTH  = 8;   // operand width, also RUN length in cycles
   localparam int CALC_ITER_W = 4;   // iteration counter width

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   // Codes are visible on the debug LEDs, so they are fixed, not tool-chosen.
   typedef enum logic [2:0] {
      ST_GET_A  = 3'b000,
      ST_GET_B  = 3'b001,
      ST_CHECK  = 3'b010,
      ST_RUN    = 3'b011,
      ST_STORE  = 3'b100,
      ST_SHOW   = 3'b101,
      ST_ERR    = 3'b110
   } state_t;

endpackage

// File: rtl/calc_sequencer_if.sv
// Bundle between the calculator sequencer and its datapath / front panel.
// Latency: n/a (wires only).
// Backpressure: none; strobes are one-shot and the datapath must accept them.
// master = sequencer side (drives strobes/status), slave = datapath/panel side.
interface calc_sequencer_if #(
   parameter int ITER_W = 4
);
   logic              enter;     // raw pushbutton level, async to clk
   logic              op_sel;    // 0 = multiply, 1 = divide
   logic              b_zero;    // B register is zero
   logic              load_a;
   logic              load_b;
   logic              div_mode;
   logic              init;
   logic              step;
   logic              load_z;
   logic              busy;
   logic              done;
   logic              err;
   logic [ITER_W-1:0] iter;
   logic [2:0]        state;

   modport master (
      input  enter, op_sel, b_zero,
      output load_a, load_b, div_mode, init, step, load_z,
             busy, done, err, iter, state
   );

   modport slave (
      output enter, op_sel, b_zero,
      input  load_a, load_b, div_mode, init, step, load_z,
             busy, done, err, iter, state
   );
endinterface

// File: rtl/calc_sequencer_enter_sync.sv
// Pushbutton conditioner: 2-flop synchronizer plus delay flop, rising-edge pulse.
// Latency: pulse in the cycle after the 2nd edge that samples enter high.
// Backpressure: none; exactly one pulse per press however long it is held.
// Ports: clk, clr (async active-low), enter_i (raw level), pulse_o (1-cycle).
module enter_sync
   import calc_pkg::*;
(
   input  logic clk,
   input  logic clr,
   input  logic enter_i,
   output logic pulse_o
);

   logic s1_q, s2_q, s3_q;

   // Reset to 1: a button already held through reset looks like "no edge"
   // and must be released and pressed again before it produces a pulse.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         s3_q <= 1'b1;
      end else begin
         s1_q <= enter_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign pulse_o = s2_q & ~s3_q;

endmodule

// File: rtl/calc_sequencer.sv
// Control FSM for the calculator: enter A, enter B, check, run WIDTH steps, store, show.
// Latency: B press at t -> init t+1, step t+2..t+1+WIDTH, load_z t+2+WIDTH, done t+3+WIDTH.
// Backpressure: presses during CHECK/RUN/STORE are dropped, never queued.
// Ports: clk, clr (async active-low), bus (calc_sequencer_if.master).
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int WIDTH  = CALC_WIDTH,
   parameter int ITER_W = CALC_ITER_W
)(
   input  logic              clk,
   input  logic              clr,
   calc_sequencer_if.master  bus
);

   state_t            state_q, state_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic              div_mode_q, div_mode_d;
   logic              enter_pulse;

   logic load_a, load_b, init, step, load_z;

   enter_sync u_enter_sync (
      .clk     (clk),
      .clr     (clr),
      .enter_i (bus.enter),
      .pulse_o (enter_pulse)
   );

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q    <= ST_GET_A;
         iter_q     <= '0;
         div_mode_q <= OP_MUL;
      end else begin
         state_q    <= state_d;
         iter_q     <= iter_d;
         div_mode_q <= div_mode_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      iter_d     = iter_q;
      div_mode_d = div_mode_q;
      load_a     = 1'b0;
      load_b     = 1'b0;
      init       = 1'b0;
      step       = 1'b0;
      load_z     = 1'b0;

      case (state_q)
         ST_GET_A: begin
            load_a = enter_pulse;
            if (enter_pulse) state_d = ST_GET_B;
         end
         ST_GET_B: begin
            load_b = enter_pulse;
            // op_sel is only looked at on this press; later changes are ignored.
            if (enter_pulse) begin
               div_mode_d = bus.op_sel;
               state_d    = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (div_mode_q == OP_DIV && bus.b_zero) begin
               state_d = ST_ERR;
            end else begin
               init    = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (iter_q == ITER_W'(WIDTH - 1)) begin
               iter_d  = '0;
               state_d = ST_STORE;
            end else begin
               iter_d  = iter_q + 1'b1;
            end
         end
         ST_STORE: begin
            load_z  = 1'b1;
            state_d = ST_SHOW;
         end
         ST_SHOW: begin
            // Leaving SHOW consumes the press; it does not also load A.
            if (enter_pulse) state_d = ST_GET_A;
         end
         ST_ERR: begin
            if (enter_pulse) state_d = ST_GET_A;
         end
         default: begin
            // Unused code 3'b111 recovers to the idle entry state.
            state_d = ST_GET_A;
            iter_d  = '0;
         end
      endcase
   end

   assign bus.load_a   = load_a;
   assign bus.load_b   = load_b;
   assign bus.init     = init;
   assign bus.step     = step;
   assign bus.load_z   = load_z;
   assign bus.div_mode = div_mode_q;
   assign bus.busy     = (state_q == ST_CHECK) || (state_q == ST_RUN) || (state_q == ST_STORE);
   assign bus.done     = (state_q == ST_SHOW);
   assign bus.err      = (state_q == ST_ERR);
   assign bus.iter     = iter_q;
   assign bus.state    = state_q;

endmodule
